dma_event_framer: RTL and testbench
===================================

DMA_EVENT_FRAMER -- requirements
Module: dma_event_framer

Interface
REQ-001 The block SHALL have parameter MAX_WORDS, default 1024, giving the maximum number of body words forwarded per event (range 1..65535).
REQ-002 The block SHALL have parameter HDR_MARKER, default 8'hBE, placed in header bits [63:56].
REQ-003 The block SHALL have parameter TRL_MARKER, default 8'hEF, placed in trailer bits [63:56].
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
- dmaClk  in  1  the single clock; every register updates on its rising edge.
- dmaRst  in  1  asynchronous, active-high reset.
REQ-005 The block SHALL have the following ports.
- enable  in  1  when high, a new event may start; an event already in progress always completes.
- dma_valid  in  1  event word valid from the DAQ.
- dma_data  in  64  event word from the DAQ.
- dma_done  in  1  marks the last word of the event.
- dma_ready  out  1  word accepted when dma_valid and dma_ready are both high.
- dmaIbMaster_tValid  out  1  output stream valid.
- dmaIbMaster_tData  out  64  output stream data.
- dmaIbMaster_tLast  out  1  high on the trailer word only.
- dmaIbSlave_tReady  in  1  downstream ready.
- evt_seq  out  32  sequence number of the next event.
- trunc_count  out  16  number of truncated events, saturating.
- frame_busy  out  1  high whenever the state is not IDLE.

Function
REQ-006 Output transfers SHALL follow the AXI-Stream handshake.
- A word transfers when tValid and tReady are both high.
- Once tValid is high, tValid, tData and tLast SHALL hold stable until the transfer.
- tValid SHALL never depend combinationally on tReady.
REQ-007 The output SHALL be a single registered stage.
- tValid, tData and tLast come directly from flops.
- The output register may load when it is empty or when it transfers in the same cycle.
REQ-008 The state machine SHALL have the states IDLE, HEADER, BODY, DRAIN and TRAILER.
REQ-009 IDLE behaviour:
- dma_ready is 0.
- When enable and dma_valid are both high, go to HEADER; the DAQ word is not consumed.
REQ-010 HEADER behaviour:
- Load the header word into the output register: {HDR_MARKER, 24'h0, evt_seq}, tLast=0.
- Go to BODY in the cycle the load occurs.
- dma_ready remains 0.
REQ-011 BODY behaviour:
- dma_ready = output register free for loading, per REQ-007.
- Each accepted DAQ word loads unchanged with tLast=0, and the body count increments.
REQ-012 BODY exit conditions:
- If an accepted word has dma_done high, go to TRAILER with truncated=0.
- Otherwise, if the body count reaches MAX_WORDS, go to DRAIN.
REQ-013 DRAIN behaviour:
- dma_ready = 1; every accepted word is discarded.
- When the accepted word has dma_done high, go to TRAILER with truncated=1.
REQ-014 TRAILER behaviour:
- Load the trailer word with tLast=1 when the output register is free: {TRL_MARKER, 7'h0, truncated, 16'h0, 16'h0, body_count[15:0]}.
- When the trailer transfers:
  - increment evt_seq, wrapping 32'hFFFFFFFF to 0;
  - increment trunc_count if the event was truncated, saturating at 16'hFFFF;
  - clear the body count;
  - go to IDLE.
REQ-015 Boundary cases:
- An event of exactly MAX_WORDS words whose last word has dma_done high is not truncated.
- A single-word event produces exactly 3 output words: header, body, trailer.
- enable falling mid-event has no effect on that event.
REQ-016 Throughput: in BODY with tReady held high, one word SHALL be forwarded per cycle.
REQ-017 Latency: a DAQ word SHALL appear on tData one cycle after acceptance.

Reset
REQ-018 While dmaRst is high, asynchronously:
- state=IDLE;
- tValid=0, tLast=0, tData=0;
- dma_ready=0, frame_busy=0;
- evt_seq=0, trunc_count=0, body count=0.
REQ-019 Reset asserted mid-event SHALL abandon the event.
- No trailer is emitted.
- evt_seq is cleared.
REQ-020 After reset deasserts, the first event starts only on a fresh dma_valid in IDLE.

Verification
REQ-021 Nominal event: enable=1, 3 words 0x11, 0x22, 0x33 (done on 0x33), tReady=1 -> output:
- 0xBE00000000000000;
- 0x11, 0x22, 0x33;
- 0xEF00000000000003 with tLast=1;
- then evt_seq=1.
REQ-022 Truncation: MAX_WORDS=4, 6-word event -> output:
- header, 4 body words;
- trailer 0xEF01000000000004;
- trunc_count=1; words 5 and 6 are dropped with dma_ready=1.
REQ-023 Backpressure: tReady randomly 50% over a 100-word event -> all 102 words arrive in order, with no duplicates and stable data while stalled.
REQ-024 Exact limit: MAX_WORDS=4, 4-word event -> trailer truncated bit=0 and count=4; trunc_count unchanged.
REQ-025 Disable and wrap: enable=0 with dma_valid=1 -> no output and dma_ready=0; evt_seq preset 0xFFFFFFFF via events -> wraps to 0.
REQ-026 Reset mid-body: assert dmaRst after 2 body words -> tValid=0 immediately, no tLast seen, evt_seq=0, next event header seq=0.

Source files
------------

// File: rtl/dma_event_framer.sv
// dma_event_framer
// Wraps each DAQ event into an AXI-Stream frame: a header word carrying the
// event sequence number, the body words unchanged (up to MAX_WORDS), then a
// trailer word carrying the truncation flag and the forwarded body count.
// Body words beyond MAX_WORDS are consumed and dropped until dma_done.
//
// Handshakes: a word moves on a channel in any cycle where its valid and
// ready are both high. The producer holds valid/data/last stable until that
// cycle. Output valid never depends combinationally on output ready.
//
// Ports:
//   dmaClk, dmaRst        clock, asynchronous active-high reset
//   enable                allows a new event to start
//   dma_valid/dma_data/dma_done/dma_ready   DAQ input channel
//   dmaIbMaster_tValid/tData/tLast, dmaIbSlave_tReady   output stream
//   evt_seq               sequence number of the next event
//   trunc_count           saturating count of truncated events
//   frame_busy            high whenever the FSM is not idle
//   fsm_state             current FSM state encoding (debug)
module dma_event_framer #(
  parameter int          MAX_WORDS  = 1024,
  parameter logic [7:0]  HDR_MARKER = 8'hBE,
  parameter logic [7:0]  TRL_MARKER = 8'hEF
) (
  input  logic        dmaClk,
  input  logic        dmaRst,
  input  logic        enable,
  input  logic        dma_valid,
  input  logic [63:0] dma_data,
  input  logic        dma_done,
  output logic        dma_ready,
  output logic        dmaIbMaster_tValid,
  output logic [63:0] dmaIbMaster_tData,
  output logic        dmaIbMaster_tLast,
  input  logic        dmaIbSlave_tReady,
  output logic [31:0] evt_seq,
  output logic [15:0] trunc_count,
  output logic        frame_busy,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_BODY    = 3'd2,
    S_DRAIN   = 3'd3,
    S_TRAILER = 3'd4
  } state_t;

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  state_t      state;
  logic [15:0] body_count;
  logic        truncated;
  logic        out_free;
  logic        accept;

  // The single output stage can take a new word when empty, or when its
  // current word leaves in this same cycle.
  assign out_free = !dmaIbMaster_tValid || dmaIbSlave_tReady;

  always_comb begin
    dma_ready = 1'b0;
    case (state)
      S_BODY:  dma_ready = out_free;
      S_DRAIN: dma_ready = 1'b1;
      default: dma_ready = 1'b0;
    endcase
  end

  assign accept     = dma_valid && dma_ready;
  assign frame_busy = (state != S_IDLE);
  assign fsm_state  = state;

  always_ff @(posedge dmaClk or posedge dmaRst) begin
    if (dmaRst) begin
      state              <= S_IDLE;
      dmaIbMaster_tValid <= 1'b0;
      dmaIbMaster_tData  <= 64'h0;
      dmaIbMaster_tLast  <= 1'b0;
      evt_seq            <= 32'h0;
      trunc_count        <= 16'h0;
      body_count         <= 16'h0;
      truncated          <= 1'b0;
    end else begin
      // A transferred word empties the stage unless a load below refills it.
      if (dmaIbMaster_tValid && dmaIbSlave_tReady) begin
        dmaIbMaster_tValid <= 1'b0;
        dmaIbMaster_tLast  <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          // The DAQ word that triggers the event stays pending for BODY.
          if (enable && dma_valid) state <= S_HEADER;
        end

        S_HEADER: begin
          if (out_free) begin
            dmaIbMaster_tValid <= 1'b1;
            dmaIbMaster_tData  <= {HDR_MARKER, 24'h0, evt_seq};
            dmaIbMaster_tLast  <= 1'b0;
            state              <= S_BODY;
          end
        end

        S_BODY: begin
          if (accept) begin
            dmaIbMaster_tValid <= 1'b1;
            dmaIbMaster_tData  <= dma_data;
            dmaIbMaster_tLast  <= 1'b0;
            body_count         <= body_count + 16'd1;
            if (dma_done) begin
              truncated <= 1'b0;
              state     <= S_TRAILER;
            end else if (body_count + 16'd1 == MAX_CNT) begin
              state <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          if (accept && dma_done) begin
            truncated <= 1'b1;
            state     <= S_TRAILER;
          end
        end

        S_TRAILER: begin
          // tLast high in the stage means the trailer is already loaded.
          if (dmaIbMaster_tValid && dmaIbMaster_tLast) begin
            if (dmaIbSlave_tReady) begin
              evt_seq    <= evt_seq + 32'd1;
              body_count <= 16'h0;
              if (truncated && (trunc_count != 16'hFFFF))
                trunc_count <= trunc_count + 16'd1;
              state <= S_IDLE;
            end
          end else if (out_free) begin
            dmaIbMaster_tValid <= 1'b1;
            dmaIbMaster_tLast  <= 1'b1;
            dmaIbMaster_tData  <= {TRL_MARKER, 7'h0, truncated, 32'h0, body_count};
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_event_framer.sv
// tb_dma_event_framer
// Directed bench for dma_event_framer. Two instances share stimulus:
// dut_a uses the default MAX_WORDS, dut_b uses MAX_WORDS=4; sel picks which
// one receives dma_valid/tReady and whose outputs are observed.
module tb_dma_event_framer;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        dma_valid;
  logic [63:0] dma_data;
  logic        dma_done;
  logic        tready;
  logic        sel;
  logic        bp_on;

  always #5 clk = ~clk;

  logic        a_ready, a_tvalid, a_tlast, a_busy;
  logic [63:0] a_tdata;
  logic [31:0] a_seq;
  logic [15:0] a_trunc;
  logic [2:0]  a_state;
  logic        b_ready, b_tvalid, b_tlast, b_busy;
  logic [63:0] b_tdata;
  logic [31:0] b_seq;
  logic [15:0] b_trunc;
  logic [2:0]  b_state;

  dma_event_framer dut_a (
    .dmaClk(clk), .dmaRst(rst), .enable(enable),
    .dma_valid(dma_valid & ~sel), .dma_data(dma_data), .dma_done(dma_done),
    .dma_ready(a_ready),
    .dmaIbMaster_tValid(a_tvalid), .dmaIbMaster_tData(a_tdata),
    .dmaIbMaster_tLast(a_tlast), .dmaIbSlave_tReady(tready & ~sel),
    .evt_seq(a_seq), .trunc_count(a_trunc), .frame_busy(a_busy),
    .fsm_state(a_state)
  );

  dma_event_framer #(.MAX_WORDS(4)) dut_b (
    .dmaClk(clk), .dmaRst(rst), .enable(enable),
    .dma_valid(dma_valid & sel), .dma_data(dma_data), .dma_done(dma_done),
    .dma_ready(b_ready),
    .dmaIbMaster_tValid(b_tvalid), .dmaIbMaster_tData(b_tdata),
    .dmaIbMaster_tLast(b_tlast), .dmaIbSlave_tReady(tready & sel),
    .evt_seq(b_seq), .trunc_count(b_trunc), .frame_busy(b_busy),
    .fsm_state(b_state)
  );

  logic        obs_ready, obs_tvalid, obs_tlast, obs_busy;
  logic [63:0] obs_tdata;
  logic [31:0] obs_seq;
  logic [15:0] obs_trunc;
  logic [2:0]  obs_state;
  assign obs_ready  = sel ? b_ready  : a_ready;
  assign obs_tvalid = sel ? b_tvalid : a_tvalid;
  assign obs_tlast  = sel ? b_tlast  : a_tlast;
  assign obs_busy   = sel ? b_busy   : a_busy;
  assign obs_tdata  = sel ? b_tdata  : a_tdata;
  assign obs_seq    = sel ? b_seq    : a_seq;
  assign obs_trunc  = sel ? b_trunc  : a_trunc;
  assign obs_state  = sel ? b_state  : a_state;

  // ---------------- scoreboard state ----------------
  logic [64:0] exp_q[$];   // {tLast, tData}
  int          n_checks;
  int          n_fail;
  logic        prev_stall;
  logic [63:0] prev_data;
  logic        prev_last;

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic last, input logic [63:0] d);
    exp_q.push_back({last, d});
  endtask

  task automatic send_word(input logic [63:0] d, input logic dn);
    bit ok;
    ok = 1'b0;
    dma_valid = 1'b1;
    dma_data  = d;
    dma_done  = dn;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clk);
      if (obs_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    dma_valid = 1'b0;
    dma_done  = 1'b0;
    check("accept_in_time", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !obs_busy) ok = 1'b1;
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks   = 0;
    n_fail     = 0;
    prev_stall = 1'b0;
    prev_data  = 64'h0;
    prev_last  = 1'b0;
    rst        = 1'b1;
    enable     = 1'b0;
    dma_valid  = 1'b0;
    dma_data   = 64'h0;
    dma_done   = 1'b0;
    tready     = 1'b1;
    sel        = 1'b0;
    bp_on      = 1'b0;

    fork
      // Output-ready driver: random when backpressure is on, else held high.
      forever begin
        @(posedge clk);
        #1;
        tready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      // Output monitor: transfers against the expected queue, plus stall stability.
      forever begin
        logic [64:0] e;
        @(negedge clk);
        if (rst) begin
          prev_stall = 1'b0;
        end else begin
          if (prev_stall) begin
            check("stall_valid", 64'(obs_tvalid), 64'd1);
            check("stall_data", obs_tdata, prev_data);
            check("stall_last", 64'(obs_tlast), 64'(prev_last));
          end
          if (obs_tvalid && tready) begin
            check("xfer_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("xfer_data", obs_tdata, e[63:0]);
              check("xfer_last", 64'(obs_tlast), 64'(e[64]));
            end
          end
          prev_stall = obs_tvalid && !tready;
          prev_data  = obs_tdata;
          prev_last  = obs_tlast;
        end
      end
    join_none

    // Reset values
    #1;
    check("rst_tvalid", 64'(a_tvalid), 64'd0);
    check("rst_tlast", 64'(a_tlast), 64'd0);
    check("rst_tdata", a_tdata, 64'h0);
    check("rst_ready", 64'(a_ready), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_seq", 64'(a_seq), 64'd0);
    check("rst_trunc", 64'(b_trunc), 64'd0);
    #21;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_rst", 64'(a_busy), 64'd0);
    enable = 1'b1;

    // Nominal 3-word event on dut_a, with one-cycle latency check
    sel = 1'b0;
    push(1'b0, 64'hBE00000000000000);
    push(1'b0, 64'h11);
    push(1'b0, 64'h22);
    push(1'b0, 64'h33);
    push(1'b1, 64'hEF00000000000003);
    send_word(64'h11, 1'b0);
    check("latency_valid", 64'(obs_tvalid), 64'd1);
    check("latency_data", obs_tdata, 64'h11);
    send_word(64'h22, 1'b0);
    send_word(64'h33, 1'b1);
    wait_idle("nominal_done");
    check("nominal_seq", 64'(obs_seq), 64'd1);

    // Truncation on dut_b (MAX_WORDS=4): 6 words, last two dropped
    sel = 1'b1;
    push(1'b0, 64'hBE00000000000000);
    for (int i = 1; i <= 4; i++) push(1'b0, 64'(i) + 64'hA0);
    push(1'b1, 64'hEF01000000000004);
    for (int i = 1; i <= 4; i++) send_word(64'(i) + 64'hA0, 1'b0);
    check("drain_state", 64'(obs_state), 64'd3);
    check("drain_ready", 64'(obs_ready), 64'd1);
    send_word(64'hA5, 1'b0);
    check("drain_ready2", 64'(obs_ready), 64'd1);
    send_word(64'hA6, 1'b1);
    wait_idle("trunc_done");
    check("trunc_count", 64'(obs_trunc), 64'd1);
    check("trunc_seq", 64'(obs_seq), 64'd1);

    // Exact limit on dut_b: 4 words, done on the 4th; enable drops mid-event
    push(1'b0, 64'hBE00000000000001);
    for (int i = 1; i <= 4; i++) push(1'b0, 64'(i) + 64'hB0);
    push(1'b1, 64'hEF00000000000004);
    send_word(64'hB1, 1'b0);
    enable = 1'b0;
    send_word(64'hB2, 1'b0);
    send_word(64'hB3, 1'b0);
    send_word(64'hB4, 1'b1);
    wait_idle("exact_done");
    enable = 1'b1;
    check("exact_trunc", 64'(obs_trunc), 64'd1);
    check("exact_seq", 64'(obs_seq), 64'd2);

    // Backpressure: 100-word event on dut_a with random tReady
    sel   = 1'b0;
    bp_on = 1'b1;
    begin
      logic [63:0] words[100];
      for (int i = 0; i < 100; i++) words[i] = {$urandom, $urandom};
      push(1'b0, 64'hBE00000000000001);
      for (int i = 0; i < 100; i++) push(1'b0, words[i]);
      push(1'b1, 64'hEF00000000000064);
      for (int i = 0; i < 100; i++) send_word(words[i], 1'(i == 99));
    end
    wait_idle("bp_done");
    bp_on = 1'b0;
    check("bp_seq", 64'(obs_seq), 64'd2);

    // Reset mid-body: header and first word go out, second word is abandoned
    @(posedge clk);
    #1;
    push(1'b0, 64'hBE00000000000002);
    push(1'b0, 64'hC1);
    send_word(64'hC1, 1'b0);
    send_word(64'hC2, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_tvalid", 64'(obs_tvalid), 64'd0);
    check("midrst_tlast", 64'(obs_tlast), 64'd0);
    check("midrst_seq", 64'(obs_seq), 64'd0);
    check("midrst_busy", 64'(obs_busy), 64'd0);
    check("midrst_queue", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push(1'b0, 64'hBE00000000000000);
    push(1'b0, 64'h77);
    push(1'b1, 64'hEF00000000000001);
    send_word(64'h77, 1'b1);
    wait_idle("postrst_done");
    check("postrst_seq", 64'(obs_seq), 64'd1);

    // Disabled: valid held high must not start an event
    enable    = 1'b0;
    dma_valid = 1'b1;
    dma_data  = 64'hDEAD;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("dis_ready", 64'(obs_ready), 64'd0);
      check("dis_tvalid", 64'(obs_tvalid), 64'd0);
      check("dis_busy", 64'(obs_busy), 64'd0);
    end
    @(posedge clk);
    #1;
    dma_valid = 1'b0;
    enable    = 1'b1;

    // Sequence wrap: preset evt_seq to all-ones, run a single-word event
    force dut_a.evt_seq = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    release dut_a.evt_seq;
    push(1'b0, 64'hBE000000FFFFFFFF);
    push(1'b0, 64'h55);
    push(1'b1, 64'hEF00000000000001);
    send_word(64'h55, 1'b1);
    wait_idle("wrap_done");
    check("wrap_seq", 64'(obs_seq), 64'd0);

    repeat (3) @(posedge clk);
    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
